sensor_conditioner: RTL
=======================

SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20'd500_000, consecutive stable cycles required to accept a raw level change.
REQ-002 Parameter LOCKOUT_CYCLES, default 24'd600_000, idle cycles enforced after each emitted event so the downstream parking FSM finishes its flash sequence.
REQ-003 Parameter NUM_SLOTS, default 4, number of valid parking slots.
REQ-004 clk  input  1  system clock; all state on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 entry_btn  input  1  raw, asynchronous, bouncing entry button/sensor.
REQ-007 exit_btn  input  1  raw, asynchronous, bouncing exit button/sensor.
REQ-008 exit_slot_sw  input  4  raw slot-number switches for the exiting car.
REQ-009 entry_sensor  output  1  one-cycle entry event pulse for the parking FSM.
REQ-010 exit_sensor  output  1  one-cycle exit event pulse for the parking FSM.
REQ-011 exit_slot  output  4  slot number for the exit event; held stable from the exit_sensor cycle until the next accepted exit.
REQ-012 slot_err  output  1  one-cycle pulse: an exit request carried slot >= NUM_SLOTS and was dropped.

Function
REQ-013 Each of entry_btn, exit_btn, exit_slot_sw[3:0] shall pass through a two-flop synchronizer.
REQ-014 Per button: a stable level register and a counter; counter increments while synced != stable, clears when equal; on reaching DEBOUNCE_CYCLES, stable takes the synced value and the counter clears.
REQ-015 A 0->1 transition of a stable level shall set that channel's pending-request flag; 1->0 transitions generate nothing.
REQ-016 On setting exit pending, the synchronized exit_slot_sw shall be captured into a pending-slot register; if the value is >= NUM_SLOTS, the request is dropped and slot_err pulses in the following cycle.
REQ-017 Pending flags are single-depth: a new edge on an already-pending channel is discarded (no queueing, no slot overwrite).
REQ-018 Arbiter FSM states: IDLE, EMIT_ENTRY, EMIT_EXIT, LOCKOUT.
REQ-019 IDLE: entry pending -> EMIT_ENTRY; else exit pending -> EMIT_EXIT; else stay. Entry has strict priority on simultaneous requests.
REQ-020 EMIT_ENTRY: entry_sensor=1 for exactly this cycle, clear entry pending, -> LOCKOUT.
REQ-021 EMIT_EXIT: exit_sensor=1 for exactly this cycle, exit_slot <= pending slot, clear exit pending, -> LOCKOUT.
REQ-022 LOCKOUT: counter loads 0 on entry, increments each cycle; at LOCKOUT_CYCLES-1 -> IDLE. Requests arriving during LOCKOUT remain pending and are served afterwards.
REQ-023 entry_sensor and exit_sensor shall never be high in the same cycle.
REQ-024 Latency raw rise to pulse, FSM idle, no bounce: 2 + DEBOUNCE_CYCLES + 2 cycles.
REQ-025 Counters sized to hold their parameter without wrap; no counter shall wrap.

Reset
REQ-026 reset clears synchronizers, stable levels, debounce/lockout counters, pending flags, pending slot; FSM -> IDLE.
REQ-027 Reset values: entry_sensor=0, exit_sensor=0, exit_slot=4'd0, slot_err=0.
REQ-028 Reset asserted mid-debounce, mid-lockout or with requests pending discards all in-flight events; a button held through reset release is accepted once its debounce completes (stable resets to 0).

Configuration
REQ-029 Macro SENSOR_DEBOUNCE_EN: defined -> debounce per REQ-014; undefined -> stable level equals the synchronized level directly (no counter), latency 4 cycles; all other behaviour identical.

Structure
REQ-030 Shared package holds arbiter state encoding (2-bit localparams) and the NUM_SLOTS default used by the parking FSM.
REQ-031 One sub-module, sensor_debounce (sync + filter + rising-edge detect, 1-bit), instantiated once per button.

Verification
REQ-032 DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8: entry_btn 0->1 held -> single entry_sensor pulse exactly 8 cycles later.
REQ-033 entry_btn toggled every 2 cycles for 20 cycles, then held low -> no entry_sensor pulse.
REQ-034 entry_btn and exit_btn rise same cycle, exit_slot_sw=2 -> entry_sensor first, exit_sensor 9 cycles later with exit_slot=2.
REQ-035 exit_btn rise with exit_slot_sw=4'd5 -> slot_err single pulse, no exit_sensor, exit_slot unchanged.
REQ-036 Second entry press during LOCKOUT -> served once after LOCKOUT; third press while pending -> dropped.
REQ-037 reset asserted during LOCKOUT with exit pending -> all outputs 0, no exit_sensor after release.

Source files
------------

// File: rtl/sensor_conditioner_pkg.sv
// Shared definitions for the sensor conditioner and the parking FSM.
// Holds the arbiter state encoding and the default slot count.
package sensor_conditioner_pkg;

   localparam int NUM_SLOTS_DEF = 4;
   localparam int SLOT_W        = 4;

   localparam logic [1:0] ST_IDLE       = 2'd0;
   localparam logic [1:0] ST_EMIT_ENTRY = 2'd1;
   localparam logic [1:0] ST_EMIT_EXIT  = 2'd2;
   localparam logic [1:0] ST_LOCKOUT    = 2'd3;

   // Bits needed to hold n without wrapping.
   function automatic int cnt_width(int n);
      return (n < 2) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/sensor_debounce.sv
// One button channel: two-flop sync, optional level filter, rise detect.
// Filter present only when SENSOR_DEBOUNCE_EN is defined.
module sensor_debounce
`ifdef SENSOR_DEBOUNCE_EN
#(
   parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500_000
)
`endif
(
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic rise
);

   logic sync_q1;
   logic sync_q2;
   logic stable;
   logic stable_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
      end else begin
         sync_q1 <= raw;
         sync_q2 <= sync_q1;
      end
   end

`ifdef SENSOR_DEBOUNCE_EN
   import sensor_conditioner_pkg::*;

   localparam int CW = cnt_width(int'(DEBOUNCE_CYCLES));
   localparam logic [CW-1:0] CNT_LAST =
      CW'(DEBOUNCE_CYCLES - 20'd1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stable <= 1'b0;
         cnt    <= '0;
      end else if (sync_q2 == stable) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         stable <= sync_q2;
         cnt    <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end
`else
   assign stable = sync_q2;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) stable_d <= 1'b0;
      else       stable_d <= stable;
   end

   assign rise = stable & ~stable_d;

endmodule

// File: rtl/sensor_conditioner.sv
// Turns raw entry/exit buttons into spaced, one-cycle parking events.
// Define SENSOR_DEBOUNCE_EN to enable the per-button level filter.
module sensor_conditioner
   import sensor_conditioner_pkg::*;
#(
   parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500_000,
   parameter logic [23:0] LOCKOUT_CYCLES  = 24'd600_000,
   parameter int          NUM_SLOTS       = NUM_SLOTS_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              entry_btn,
   input  logic              exit_btn,
   input  logic [SLOT_W-1:0] exit_slot_sw,
   output logic              entry_sensor,
   output logic              exit_sensor,
   output logic [SLOT_W-1:0] exit_slot,
   output logic              slot_err
);

   localparam int LW = cnt_width(int'(LOCKOUT_CYCLES));
   localparam logic [LW-1:0] LOCK_LAST =
      LW'(LOCKOUT_CYCLES - 24'd1);

   logic              entry_rise;
   logic              exit_rise;
   logic [SLOT_W-1:0] slot_q1;
   logic [SLOT_W-1:0] slot_q2;
   logic              slot_bad;
   logic              entry_pend;
   logic              exit_pend;
   logic [SLOT_W-1:0] pend_slot;
   logic [1:0]        state;
   logic [LW-1:0]     lock_cnt;

`ifdef SENSOR_DEBOUNCE_EN
   sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_entry_db (
      .clk(clk), .reset(reset), .raw(entry_btn), .rise(entry_rise)
   );
   sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit_db (
      .clk(clk), .reset(reset), .raw(exit_btn), .rise(exit_rise)
   );
`else
   logic unused_db_cfg;
   assign unused_db_cfg = ^DEBOUNCE_CYCLES;

   sensor_debounce u_entry_db (
      .clk(clk), .reset(reset), .raw(entry_btn), .rise(entry_rise)
   );
   sensor_debounce u_exit_db (
      .clk(clk), .reset(reset), .raw(exit_btn), .rise(exit_rise)
   );
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_q1 <= '0;
         slot_q2 <= '0;
      end else begin
         slot_q1 <= exit_slot_sw;
         slot_q2 <= slot_q1;
      end
   end

   assign slot_bad = 32'(slot_q2) >= 32'(NUM_SLOTS);

   // Single-depth requests: an edge on a busy channel is ignored.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         entry_pend <= 1'b0;
         exit_pend  <= 1'b0;
         pend_slot  <= '0;
         slot_err   <= 1'b0;
      end else begin
         slot_err <= exit_rise & ~exit_pend & slot_bad;
         if (entry_rise && !entry_pend)
            entry_pend <= 1'b1;
         else if (state == ST_EMIT_ENTRY)
            entry_pend <= 1'b0;
         if (exit_rise && !exit_pend) begin
            pend_slot <= slot_q2;
            exit_pend <= ~slot_bad;
         end else if (state == ST_EMIT_EXIT) begin
            exit_pend <= 1'b0;
         end
      end
   end

   // Lockout window is counted from the emit cycle itself.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         lock_cnt  <= '0;
         exit_slot <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               lock_cnt <= '0;
               if (entry_pend) begin
                  state <= ST_EMIT_ENTRY;
               end else if (exit_pend) begin
                  state     <= ST_EMIT_EXIT;
                  exit_slot <= pend_slot;
               end
            end
            ST_EMIT_ENTRY, ST_EMIT_EXIT: begin
               lock_cnt <= LW'(1);
               state    <= ST_LOCKOUT;
            end
            ST_LOCKOUT: begin
               if (lock_cnt >= LOCK_LAST) state <= ST_IDLE;
               else lock_cnt <= lock_cnt + LW'(1);
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign entry_sensor = (state == ST_EMIT_ENTRY);
   assign exit_sensor  = (state == ST_EMIT_EXIT);

endmodule
